uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter (8N1, start/busy handshake) between N_REQ byte requesters.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared constants and types for the UART transmit arbiter.
//   CPB        : clock cycles per bit (50 MHz / 115200 baud)
//   BYTE_W     : width of one transmitted byte
//   arb_state_e: arbiter FSM state encoding
//   rot_idx    : (base + step) wrapped into 0..n-1, for base < n and step <= n
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam int CPB    = 434;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_e;

   function automatic int rot_idx(input int base, input int step, input int n);
      int s;
      s = base + step;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational rotate-priority encoder. Scans req starting one past ptr
//   and wrapping around; the first set bit wins.
//   Ports:
//     req   in  N_REQ          request vector
//     ptr   in  clog2(N_REQ)   index of the last winner
//     found out 1              at least one request is set
//     idx   out clog2(N_REQ)   index of the winning request (0 when !found)
// ----------------------------------------------------------------------------
module rr_pick
   import uart_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic                     found,
   output logic [$clog2(N_REQ)-1:0] idx
);

   localparam int IW = $clog2(N_REQ);

   logic [IW-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      // Walk from the farthest position to the nearest so the requester
      // closest to ptr+1 is the last one written and therefore wins.
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IW'(rot_idx(int'(ptr), k, N_REQ));
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one 8N1 UART transmitter between N_REQ byte requesters using
//   round-robin arbitration, with an optional per-requester burst lock that
//   keeps a multi-byte frame together (capped at MAX_BURST bytes before a
//   forced rotation). Flags a transmitter that does not raise tx_busy within
//   ACK_TIMEOUT cycles of a start pulse.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req          per-requester byte ready (held until gnt)
//     req_lock     per-requester "more bytes follow in this frame"
//     req_data     byte i at [8*i+7:8*i]
//     gnt          one-hot 1-cycle pulse, byte taken from requester i
//     tx_start     1-cycle launch pulse to the transmitter
//     tx_data      launched byte, held until the next launch
//     tx_busy      transmitter busy from launch to end of stop bit
//     owner        current / last granted requester
//     owner_valid  byte in flight or lock held
//     ack_err      1-cycle pulse, transmitter never acknowledged a launch
// ----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int MAX_BURST   = 16,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_lock,
   input  logic [BYTE_W*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]          gnt,
   output logic                      tx_start,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      tx_busy,
   output logic [$clog2(N_REQ)-1:0]  owner,
   output logic                      owner_valid,
   output logic                      ack_err
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [BW-1:0] BURST_CAP = BW'(MAX_BURST);
   localparam logic [TW-1:0] ACK_LIMIT = TW'(ACK_TIMEOUT);

   arb_state_e        state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic              lock_q, lock_d;
   logic [BW-1:0]     burst_q, burst_d;
   logic [TW-1:0]     ack_cnt_q, ack_cnt_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic              tx_start_q, tx_start_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;
   logic              owner_valid_q, owner_valid_d;
   logic              ack_err_q, ack_err_d;

   logic              rr_found;
   logic [IW-1:0]     rr_idx;
   logic              pick_en;
   logic [IW-1:0]     pick_idx;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (rr_found),
      .idx   (rr_idx)
   );

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      lock_d        = lock_q;
      burst_d       = burst_q;
      ack_cnt_d     = ack_cnt_q;
      gnt_d         = '0;
      tx_start_d    = 1'b0;
      tx_data_d     = tx_data_q;
      ack_err_d     = 1'b0;
      pick_en       = 1'b0;
      pick_idx      = owner_q;

      case (state_q)
         ARB: begin
            // Owner withdrew its request while holding the lock: release it.
            if (lock_q && !req[owner_q]) lock_d = 1'b0;
            // A stale tx_busy (e.g. left over across a reset) blocks launch.
            if (!tx_busy) begin
               if (lock_q && req[owner_q] && (burst_q != BURST_CAP)) begin
                  pick_en  = 1'b1;
                  pick_idx = owner_q;
                  burst_d  = burst_q + BW'(1);
               end else if (rr_found) begin
                  // Also covers the burst cap: ptr equals owner while locked,
                  // so the scan starts at owner+1.
                  pick_en  = 1'b1;
                  pick_idx = rr_idx;
                  burst_d  = BW'(1);
               end
            end
            if (pick_en) begin
               gnt_d      = N_REQ'(1) << pick_idx;
               tx_start_d = 1'b1;
               for (int i = 0; i < N_REQ; i++) begin
                  if (pick_idx == IW'(i)) tx_data_d = req_data[i*BYTE_W +: BYTE_W];
               end
               owner_d    = pick_idx;
               ptr_d      = pick_idx;
               lock_d     = req_lock[pick_idx];
               ack_cnt_d  = '0;
               state_d    = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else begin
               if (ack_cnt_q != ACK_LIMIT) ack_cnt_d = ack_cnt_q + TW'(1);
               if (ack_cnt_d == ACK_LIMIT) begin
                  ack_err_d = 1'b1;
                  lock_d    = 1'b0;
                  burst_d   = '0;
                  state_d   = ARB;
               end
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) state_d = ARB;
         end
         default: state_d = ARB;
      endcase

      owner_valid_d = (state_d != ARB) || lock_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARB;
         ptr_q         <= IW'(N_REQ - 1);
         owner_q       <= '0;
         lock_q        <= 1'b0;
         burst_q       <= '0;
         ack_cnt_q     <= '0;
         gnt_q         <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         owner_valid_q <= 1'b0;
         ack_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         lock_q        <= lock_d;
         burst_q       <= burst_d;
         ack_cnt_q     <= ack_cnt_d;
         gnt_q         <= gnt_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         owner_valid_q <= owner_valid_d;
         ack_err_q     <= ack_err_d;
      end
   end

   assign gnt         = gnt_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign owner       = owner_q;
   assign owner_valid = owner_valid_q;
   assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter. Each phase loads per-requester byte
//   lists; a reference model turns them into the expected launch order, which
//   a monitor compares against every tx_start. A transmitter model answers
//   launches with tx_busy (bit time scaled down from CPB to keep runs short).
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N        = 4;
   localparam int MAXB     = 16;
   localparam int ACKTO    = 4;
   localparam int BUSY_MAX = CPB / 20;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   req_lock;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   gnt;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic [1:0]     owner;
   logic           owner_valid;
   logic           ack_err;

   uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB), .ACK_TIMEOUT(ACKTO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_lock    (req_lock),
      .req_data    (req_data),
      .gnt         (gnt),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .owner       (owner),
      .owner_valid (owner_valid),
      .ack_err     (ack_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] rq_mem [N][64];   // {lock, byte}
   int         rq_len [N];
   int         rq_pos [N];

   int  n_chk, n_fail;
   int  cyc, last_start, err_seen, busy_left;
   int  m_ptr, m_owner, m_burst;
   bit  m_lock;
   bit  no_ack, long_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr   = N - 1;
      m_owner = 0;
      m_burst = 0;
      m_lock  = 0;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         rq_len[i] = 0;
         rq_pos[i] = 0;
      end
   endtask

   task automatic add_byte(input int i, input logic [7:0] d, input logic l);
      rq_mem[i][rq_len[i]] = {l, d};
      rq_len[i]++;
   endtask

   // Reference model: replays the loaded byte lists under the arbitration
   // rules and queues the launch order the arbiter must produce.
   task automatic predict();
      int   pos [N];
      bit   any;
      int   j, c;
      exp_t e;
      for (int i = 0; i < N; i++) pos[i] = 0;
      for (int g = 0; g < 400; g++) begin
         any = 0;
         for (int i = 0; i < N; i++) if (pos[i] < rq_len[i]) any = 1;
         if (!any) break;
         if (m_lock && pos[m_owner] >= rq_len[m_owner]) m_lock = 0;
         if (m_lock && m_burst < MAXB) begin
            j = m_owner;
            m_burst++;
         end else begin
            j = -1;
            for (int d = 1; d <= N && j < 0; d++) begin
               c = (m_ptr + d) % N;
               if (pos[c] < rq_len[c]) j = c;
            end
            m_burst = 1;
         end
         e.idx  = j;
         e.data = rq_mem[j][pos[j]][7:0];
         exp_q.push_back(e);
         m_lock  = rq_mem[j][pos[j]][8];
         m_owner = j;
         m_ptr   = j;
         pos[j]++;
         if (no_ack) begin
            m_lock  = 0;
            m_burst = 0;
         end
      end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (t < 4000) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !tx_busy) break;
         t++;
      end
      chk({name, "_drain"}, 32'(t < 4000), 1);
      exp_q.delete();
      repeat (6) @(negedge clk);
      #1;
      m_lock = 0;   // idle arbiter drops a lock whose owner has nothing pending
      chk({name, "_idle_owner_valid"}, owner_valid, 0);
      chk({name, "_idle_owner"}, owner, m_owner);
      chk({name, "_idle_tx_start"}, tx_start, 0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_gnt"}, gnt, 0);
      chk({name, "_tx_start"}, tx_start, 0);
      chk({name, "_tx_data"}, tx_data, 0);
      chk({name, "_owner"}, owner, 0);
      chk({name, "_owner_valid"}, owner_valid, 0);
      chk({name, "_ack_err"}, ack_err, 0);
   endtask

   // Requesters: present the current byte, advance after each gnt.
   initial begin
      req      = '0;
      req_lock = '0;
      req_data = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (gnt[i] && rst_n) rq_pos[i]++;
            if (rq_pos[i] < rq_len[i]) begin
               req[i]             = 1'b1;
               req_lock[i]        = rq_mem[i][rq_pos[i]][8];
               req_data[i*8 +: 8] = rq_mem[i][rq_pos[i]][7:0];
            end else begin
               req[i]      = 1'b0;
               req_lock[i] = 1'b0;
            end
         end
      end
   end

   // Transmitter: busy for a random number of cycles after each launch,
   // or silent when no_ack is set.
   initial begin
      tx_busy   = 1'b0;
      busy_left = 0;
      forever begin
         @(negedge clk);
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
         end
         if (tx_start && rst_n && !no_ack) begin
            tx_busy   = 1'b1;
            busy_left = long_busy ? 40 : int'($urandom_range(2, BUSY_MAX));
         end
      end
   end

   // Monitor: compares each launch against the scoreboard.
   initial begin
      bit   busy_s;
      exp_t e;
      forever begin
         @(posedge clk);
         busy_s = tx_busy;
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            chk("gnt_vs_tx_start", 32'(gnt != '0), 32'(tx_start));
            chk("gnt_onehot", 32'($onehot0(gnt)), 1);
            if (tx_start) begin
               chk("launch_while_busy", 32'(busy_s), 0);
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_launch: gnt=%b tx_data=%h, no byte expected", gnt, tx_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("gnt_idx", gnt, 32'(1) << e.idx);
                  chk("tx_data", tx_data, e.data);
                  chk("owner", owner, e.idx);
                  chk("owner_valid_busy", owner_valid, 1);
               end
               last_start = cyc;
            end
            if (ack_err) begin
               err_seen++;
               chk("ack_err_delay", cyc - last_start, ACKTO);
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      n_chk = 0; n_fail = 0; cyc = 0; last_start = 0; err_seen = 0;
      rst_n = 1'b0; no_ack = 0; long_busy = 0;
      model_reset();

      // Reset with all requesters pending, then plain round robin.
      clear_reqs();
      add_byte(0, 8'hA0, 1'b0);
      add_byte(0, 8'hA0, 1'b0);
      add_byte(1, 8'hA1, 1'b0);
      add_byte(2, 8'hA2, 1'b0);
      add_byte(3, 8'hA3, 1'b0);
      predict();
      repeat (4) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      drain("rr");

      // Move the pointer to requester 3 so requester 0 is next in line.
      clear_reqs();
      add_byte(3, 8'h5A, 1'b0);
      predict();
      drain("prep");

      // Locked 3-byte frame on requester 0 while requester 2 waits.
      clear_reqs();
      add_byte(0, 8'h11, 1'b1);
      add_byte(0, 8'h22, 1'b1);
      add_byte(0, 8'h33, 1'b0);
      add_byte(2, 8'h44, 1'b0);
      predict();
      drain("lock");

      // Requester 0 locked for longer than the burst cap, requester 1 waiting.
      clear_reqs();
      for (int k = 0; k < 18; k++) add_byte(0, 8'(8'h40 + k), 1'b1);
      add_byte(1, 8'hB1, 1'b0);
      predict();
      drain("burst");

      // Transmitter never acknowledges.
      no_ack   = 1;
      err_seen = 0;
      clear_reqs();
      add_byte(1, 8'h5B, 1'b0);
      add_byte(3, 8'h7C, 1'b1);
      predict();
      drain("timeout");
      chk("ack_err_count", err_seen, 2);
      no_ack = 0;

      // Random traffic.
      for (int p = 0; p < 10; p++) begin
         clear_reqs();
         for (int i = 0; i < N; i++) begin
            t = int'($urandom_range(0, 4));
            for (int k = 0; k < t; k++) add_byte(i, 8'($urandom), 1'($urandom_range(0, 1)));
         end
         predict();
         drain("random");
      end

      // Asynchronous reset while the transmitter is still busy.
      long_busy = 1;
      clear_reqs();
      add_byte(2, 8'hC6, 1'b0);
      predict();
      t = 0;
      while (!tx_busy && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("mid_busy_seen", 32'(tx_busy), 1);
      long_busy = 0;
      repeat (3) @(negedge clk);
      chk("mid_owner_valid", owner_valid, 1);
      chk("mid_tx_data", tx_data, 8'hC6);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      chk("async_reset_queue", exp_q.size(), 0);
      model_reset();
      clear_reqs();
      for (int i = 0; i < N; i++) begin
         t = int'($urandom_range(1, 3));
         for (int k = 0; k < t; k++) add_byte(i, 8'($urandom), 1'($urandom_range(0, 1)));
      end
      predict();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      drain("after_reset");
      chk("ack_err_total", err_seen, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
